// File: rtl/edf_ic_pkg.sv
// Shared definitions for the EDF interrupt controller: register map,
// CTRL bit layout, trigger mode and the per-channel configuration record.
package edf_ic_pkg;

    // Register index within a channel (cfg_addr_i[0])
    localparam logic REG_CTRL   = 1'b0;
    localparam logic REG_OFFSET = 1'b1;

    // CTRL bit positions
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_BIT = 1;
    localparam int CTRL_IP_BIT   = 2;
    localparam int CTRL_BUSY_BIT = 3;

    typedef enum logic {
        MODE_LEVEL = 1'b0,
        MODE_EDGE  = 1'b1
    } trig_mode_e;

    // Offset is held in a full 32-bit field; bits at and above OffWidth stay zero.
    typedef struct packed {
        logic       en;
        trig_mode_e mode;
        logic [31:0] offset;
    } channel_cfg_t;

    // Assemble the CTRL read word from configuration and live status.
    function automatic logic [31:0] ctrl_word(input channel_cfg_t cfg,
                                              input logic ip,
                                              input logic busy);
        logic [31:0] w;
        w                = '0;
        w[CTRL_EN_BIT]   = cfg.en;
        w[CTRL_MODE_BIT] = cfg.mode;
        w[CTRL_IP_BIT]   = ip;
        w[CTRL_BUSY_BIT] = busy;
        return w;
    endfunction

endpackage

// File: rtl/edf_gw_chan.sv
// One interrupt gateway channel: request detection, timestamp capture,
// pending/in-service tracking and the absolute deadline of its request.
module edf_gw_chan
    import edf_ic_pkg::*;
#(
    parameter int TsWidth  = 64,
    parameter int OffWidth = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               irq,
    input  logic [TsWidth-1:0] mtime,
    input  logic               claim,
    input  logic               complete,
    input  logic               ctrl_we,
    input  logic               off_we,
    input  logic [31:0]        wdata,
    output logic [TsWidth-1:0] dl,
    output logic               ip,
    output logic               busy,
    output channel_cfg_t       cfg
);

    localparam logic [31:0] OffMask =
        (OffWidth >= 32) ? 32'hFFFF_FFFF : ((32'd1 << OffWidth) - 32'd1);

    logic               prev_irq;
    logic [TsWidth-1:0] timestamp;
    logic               req;
    logic               acc_raw;
    logic               claim_hit;
    logic               accept;

    // Request qualification; a claim also lands on a request arriving in the
    // same cycle, which leaves the channel busy and drops that request.
    always_comb begin
        req       = (cfg.mode == MODE_EDGE) ? (irq & ~prev_irq) : irq;
        acc_raw   = req & cfg.en & ~ip & ~busy;
        claim_hit = claim & (ip | acc_raw);
        accept    = acc_raw & ~claim_hit & ~complete;
    end

    // Previous line level for edge detection, tracked independent of EN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) prev_irq <= 1'b0;
        else         prev_irq <= irq;
    end

    // Configuration registers written through the config bus.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg <= '0;
        end else begin
            if (ctrl_we) begin
                cfg.en   <= wdata[CTRL_EN_BIT];
                cfg.mode <= trig_mode_e'(wdata[CTRL_MODE_BIT]);
            end
            if (off_we) cfg.offset <= wdata & OffMask;
        end
    end

    // Pending / in-service state; later assignments take priority
    // (claim over accept, complete over claim, disable over everything).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ip        <= 1'b0;
            busy      <= 1'b0;
            timestamp <= '0;
        end else begin
            if (accept) begin
                ip        <= 1'b1;
                timestamp <= mtime;
            end
            if (claim_hit) begin
                ip   <= 1'b0;
                busy <= 1'b1;
            end
            if (complete) busy <= 1'b0;
            if (ctrl_we && !wdata[CTRL_EN_BIT]) ip <= 1'b0;
        end
    end

    // Absolute deadline, modulo 2^TsWidth; an offset rewrite retargets it at once.
    assign dl = timestamp + TsWidth'(cfg.offset);

endmodule

// File: rtl/edf_gateway_array.sv
// Multi-channel EDF interrupt gateway: channel array, config bus decode,
// registered read port and registered earliest-deadline arbiter.
module edf_gateway_array
    import edf_ic_pkg::*;
#(
    parameter int NumIrq   = 8,
    parameter int TsWidth  = 64,
    parameter int OffWidth = 32,
    parameter int IdWidth  = (NumIrq > 1) ? $clog2(NumIrq) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [63:0]        mtime_i,
    input  logic [NumIrq-1:0]  irq_i,
    input  logic               claim_i,
    input  logic [IdWidth-1:0] claim_id_i,
    input  logic               complete_i,
    input  logic [IdWidth-1:0] complete_id_i,
    input  logic               cfg_req_i,
    input  logic               cfg_we_i,
    input  logic [IdWidth:0]   cfg_addr_i,
    input  logic [31:0]        cfg_wdata_i,
    output logic [31:0]        cfg_rdata_o,
    output logic               irq_o,
    output logic [IdWidth-1:0] irq_id_o,
    output logic [TsWidth-1:0] irq_dl_o,
    output logic [NumIrq-1:0]  ip_o
);

    logic [IdWidth-1:0] cfg_ch;
    logic               cfg_reg;
    logic               cfg_ch_ok;
    logic [31:0]        rd_word;

    logic [NumIrq-1:0]  ctrl_we;
    logic [NumIrq-1:0]  off_we;
    logic [NumIrq-1:0]  claim_sel;
    logic [NumIrq-1:0]  complete_sel;
    logic [NumIrq-1:0]  ip_w;
    logic [NumIrq-1:0]  busy_w;
    logic [TsWidth-1:0] dl_w  [NumIrq];
    channel_cfg_t       cfg_w [NumIrq];

    logic               win_vld;
    logic [IdWidth-1:0] win_id;
    logic [TsWidth-1:0] win_dl;

    assign cfg_ch    = cfg_addr_i[IdWidth:1];
    assign cfg_reg   = cfg_addr_i[0];
    assign cfg_ch_ok = ({{(32-IdWidth){1'b0}}, cfg_ch} < 32'(NumIrq));

    for (genvar gi = 0; gi < NumIrq; gi++) begin : g_chan
        logic wr_sel;
        assign wr_sel           = cfg_req_i & cfg_we_i & cfg_ch_ok & (cfg_ch == IdWidth'(gi));
        assign ctrl_we[gi]      = wr_sel & (cfg_reg == REG_CTRL);
        assign off_we[gi]       = wr_sel & (cfg_reg == REG_OFFSET);
        assign claim_sel[gi]    = claim_i & (claim_id_i == IdWidth'(gi));
        assign complete_sel[gi] = complete_i & (complete_id_i == IdWidth'(gi));

        edf_gw_chan #(
            .TsWidth  (TsWidth),
            .OffWidth (OffWidth)
        ) u_chan (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .irq      (irq_i[gi]),
            .mtime    (mtime_i[TsWidth-1:0]),
            .claim    (claim_sel[gi]),
            .complete (complete_sel[gi]),
            .ctrl_we  (ctrl_we[gi]),
            .off_we   (off_we[gi]),
            .wdata    (cfg_wdata_i),
            .dl       (dl_w[gi]),
            .ip       (ip_w[gi]),
            .busy     (busy_w[gi]),
            .cfg      (cfg_w[gi])
        );
    end

    // Read mux over the addressed channel; unmapped channels read as zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NumIrq; i++) begin
            if (cfg_ch_ok && (cfg_ch == IdWidth'(i))) begin
                rd_word = (cfg_reg == REG_CTRL) ? ctrl_word(cfg_w[i], ip_w[i], busy_w[i])
                                                : cfg_w[i].offset;
            end
        end
    end

    // Registered read data, held between requests.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        cfg_rdata_o <= '0;
        else if (cfg_req_i) cfg_rdata_o <= rd_word;
    end

    // Earliest-deadline search over pending channels; strict compare keeps
    // the lowest index on ties.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        win_dl  = '0;
        for (int i = 0; i < NumIrq; i++) begin
            if (ip_w[i] && (!win_vld || (dl_w[i] < win_dl))) begin
                win_vld = 1'b1;
                win_id  = IdWidth'(i);
                win_dl  = dl_w[i];
            end
        end
    end

    // Arbiter result and pending vector registered together for the core.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_o    <= 1'b0;
            irq_id_o <= '0;
            irq_dl_o <= '0;
            ip_o     <= '0;
        end else begin
            irq_o    <= win_vld;
            irq_id_o <= win_id;
            irq_dl_o <= win_dl;
            ip_o     <= ip_w;
        end
    end

endmodule

// File: tb/tb_edf_gateway_array.sv
// Directed bench for edf_gateway_array with a behavioural reference model.
module tb_edf_gateway_array;

    logic        clk;
    logic        rst_n;
    logic [63:0] mtime;
    logic [7:0]  irq;
    logic        claim;
    logic [2:0]  claim_id;
    logic        complete;
    logic [2:0]  complete_id;
    logic        cfg_req;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        irq_out;
    logic [2:0]  irq_id;
    logic [63:0] irq_dl;
    logic [7:0]  ip_out;

    int checks   = 0;
    int failures = 0;
    logic chk_on = 1'b0;

    // Reference model state
    logic        m_en   [8];
    logic        m_mode [8];
    logic [31:0] m_off  [8];
    logic [63:0] m_ts   [8];
    logic        m_ip   [8];
    logic        m_busy [8];
    logic        m_prev [8];
    logic        e_irq;
    logic [2:0]  e_id;
    logic [63:0] e_dl;
    logic [7:0]  e_ip;
    logic [31:0] e_rdata;

    edf_gateway_array #(
        .NumIrq   (8),
        .TsWidth  (64),
        .OffWidth (32)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .mtime_i       (mtime),
        .irq_i         (irq),
        .claim_i       (claim),
        .claim_id_i    (claim_id),
        .complete_i    (complete),
        .complete_id_i (complete_id),
        .cfg_req_i     (cfg_req),
        .cfg_we_i      (cfg_we),
        .cfg_addr_i    (cfg_addr),
        .cfg_wdata_i   (cfg_wdata),
        .cfg_rdata_o   (cfg_rdata),
        .irq_o         (irq_out),
        .irq_id_o      (irq_id),
        .irq_dl_o      (irq_dl),
        .ip_o          (ip_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] dl_of(input int c);
        return m_ts[c] + {32'd0, m_off[c]};
    endfunction

    // Advance the model by one clock using the inputs the DUT sampled.
    task automatic model_step();
        logic [2:0] rc;
        logic rq, would_acc, claimed, completed, wr_ctrl, wr_off, beaten;
        if (!rst_n) begin
            for (int c = 0; c < 8; c++) begin
                m_en[c] = 0; m_mode[c] = 0; m_off[c] = 0; m_ts[c] = 0;
                m_ip[c] = 0; m_busy[c] = 0; m_prev[c] = 0;
            end
            e_irq = 0; e_id = 0; e_dl = 0; e_ip = 0; e_rdata = 0;
        end else begin
            // outputs registered from the state before this edge
            e_irq = 0; e_id = 0; e_dl = 0;
            for (int c = 0; c < 8; c++) begin
                if (m_ip[c]) begin
                    beaten = 0;
                    for (int d = 0; d < 8; d++)
                        if (d != c && m_ip[d] &&
                            (dl_of(d) < dl_of(c) || (dl_of(d) == dl_of(c) && d < c)))
                            beaten = 1;
                    if (!beaten) begin
                        e_irq = 1; e_id = 3'(c); e_dl = dl_of(c);
                    end
                end
                e_ip[c] = m_ip[c];
            end
            if (cfg_req) begin
                rc = cfg_addr[3:1];
                e_rdata = cfg_addr[0] ? m_off[rc]
                        : {28'd0, m_busy[rc], m_ip[rc], m_mode[rc], m_en[rc]};
            end
            // channel state
            for (int c = 0; c < 8; c++) begin
                rq        = m_mode[c] ? (irq[c] & ~m_prev[c]) : irq[c];
                would_acc = rq && m_en[c] && !m_ip[c] && !m_busy[c];
                claimed   = claim && claim_id == 3'(c) && (m_ip[c] || would_acc);
                completed = complete && complete_id == 3'(c);
                wr_ctrl   = cfg_req && cfg_we && cfg_addr[3:1] == 3'(c) && !cfg_addr[0];
                wr_off    = cfg_req && cfg_we && cfg_addr[3:1] == 3'(c) && cfg_addr[0];
                if (would_acc && !claimed && !completed) begin
                    m_ip[c] = 1; m_ts[c] = mtime;
                end
                if (claimed) begin m_ip[c] = 0; m_busy[c] = 1; end
                if (completed) m_busy[c] = 0;
                if (wr_ctrl) begin
                    m_en[c] = cfg_wdata[0]; m_mode[c] = cfg_wdata[1];
                    if (!cfg_wdata[0]) m_ip[c] = 0;
                end
                if (wr_off) m_off[c] = cfg_wdata;
                m_prev[c] = irq[c];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cfg_write(input int ch, input logic rg, input logic [31:0] data);
        cfg_req = 1; cfg_we = 1; cfg_addr = {3'(ch), rg}; cfg_wdata = data;
        tick();
        cfg_req = 0; cfg_we = 0;
    endtask

    task automatic cfg_read(input int ch, input logic rg, output logic [31:0] data);
        cfg_req = 1; cfg_we = 0; cfg_addr = {3'(ch), rg};
        tick();
        cfg_req = 0;
        data = cfg_rdata;
    endtask

    task automatic do_claim(input int ch);
        claim = 1; claim_id = 3'(ch); tick(); claim = 0;
    endtask

    task automatic do_complete(input int ch);
        complete = 1; complete_id = 3'(ch); tick(); complete = 0;
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("irq_o", {63'd0, irq_out}, {63'd0, e_irq});
            chk("irq_id_o", {61'd0, irq_id}, {61'd0, e_id});
            chk("irq_dl_o", irq_dl, e_dl);
            chk("ip_o", {56'd0, ip_out}, {56'd0, e_ip});
            chk("cfg_rdata_o", {32'd0, cfg_rdata}, {32'd0, e_rdata});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        rst_n = 0; mtime = 0; irq = 0; claim = 0; claim_id = 0; complete = 0;
        complete_id = 0; cfg_req = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
        tick(); tick(); tick();
        chk("rst_irq_o", {63'd0, irq_out}, 64'd0);
        chk("rst_irq_id_o", {61'd0, irq_id}, 64'd0);
        chk("rst_irq_dl_o", irq_dl, 64'd0);
        chk("rst_ip_o", {56'd0, ip_out}, 64'd0);
        chk("rst_cfg_rdata_o", {32'd0, cfg_rdata}, 64'd0);
        rst_n = 1;
        chk_on = 1;
        tick();

        // ch2 level, offset 100, request at mtime 1000
        cfg_write(2, 1'b0, 32'h1);
        cfg_write(2, 1'b1, 32'd100);
        mtime = 1000; irq[2] = 1; tick();
        mtime = 1001; tick();
        chk("t1_irq_o", {63'd0, irq_out}, 64'd1);
        chk("t1_irq_id", {61'd0, irq_id}, 64'd2);
        chk("t1_irq_dl", irq_dl, 64'd1100);
        chk("t1_ip2", {63'd0, ip_out[2]}, 64'd1);
        cfg_read(2, 1'b1, rd);
        chk("t1_offset_rd", {32'd0, rd}, 64'd100);
        do_claim(2);
        irq[2] = 0; do_complete(2); tick();

        // ch1 offset 50 at 2000, ch3 offset 10 at 2030
        cfg_write(1, 1'b0, 32'h1); cfg_write(1, 1'b1, 32'd50);
        cfg_write(3, 1'b0, 32'h1); cfg_write(3, 1'b1, 32'd10);
        mtime = 2000; irq[1] = 1; tick();
        mtime = 2030; irq[3] = 1; tick();
        mtime = 2031; tick();
        chk("t2_id3", {61'd0, irq_id}, 64'd3);
        chk("t2_dl2040", irq_dl, 64'd2040);
        do_claim(3); tick();
        chk("t2_id1", {61'd0, irq_id}, 64'd1);
        chk("t2_dl2050", irq_dl, 64'd2050);
        irq[1] = 0; irq[3] = 0;
        do_claim(1); do_complete(1); do_complete(3); tick();

        // equal deadlines on ch4/ch5, level re-pend after complete
        cfg_write(4, 1'b0, 32'h1); cfg_write(4, 1'b1, 32'd30);
        cfg_write(5, 1'b0, 32'h1); cfg_write(5, 1'b1, 32'd30);
        mtime = 3000; irq[4] = 1; irq[5] = 1; tick();
        mtime = 3001; tick();
        chk("t3_tie_id4", {61'd0, irq_id}, 64'd4);
        chk("t3_tie_dl", irq_dl, 64'd3030);
        do_claim(4); tick(); tick();
        chk("t3_no_repend", {63'd0, ip_out[4]}, 64'd0);
        chk("t3_id5", {61'd0, irq_id}, 64'd5);
        mtime = 3100; do_complete(4);
        mtime = 3105; tick();
        mtime = 3106; tick();
        chk("t3_repend", {63'd0, ip_out[4]}, 64'd1);
        do_claim(5); tick();
        chk("t3_new_ts_id", {61'd0, irq_id}, 64'd4);
        chk("t3_new_ts_dl", irq_dl, 64'd3135);
        irq[4] = 0; irq[5] = 0;
        do_claim(4); do_complete(4); do_complete(5); tick();

        // ch0 edge mode: pulse while busy is dropped
        cfg_write(0, 1'b0, 32'h3);
        mtime = 4000; irq[0] = 1; tick();
        irq[0] = 0; tick();
        do_claim(0);
        irq[0] = 1; tick();
        irq[0] = 0; tick();
        do_complete(0); tick(); tick();
        chk("t4_edge_dropped", {63'd0, ip_out[0]}, 64'd0);
        chk("t4_irq_low", {63'd0, irq_out}, 64'd0);
        mtime = 4100; irq[0] = 1; tick();
        irq[0] = 0; tick();
        chk("t4_new_edge", {63'd0, ip_out[0]}, 64'd1);
        chk("t4_new_edge_dl", irq_dl, 64'd4100);
        do_claim(0); do_complete(0); tick();

        // claim and rising request together on ch6
        cfg_write(6, 1'b0, 32'h1);
        irq[6] = 1; claim = 1; claim_id = 3'd6; tick();
        claim = 0; irq[6] = 0; tick();
        cfg_read(6, 1'b0, rd);
        chk("t5_ctrl_busy", {32'd0, rd}, 64'h9);
        chk("t5_ip6", {63'd0, ip_out[6]}, 64'd0);
        do_complete(6); tick();

        // deadline wrap on ch7, then disable while pending
        cfg_write(7, 1'b0, 32'h1); cfg_write(7, 1'b1, 32'd20);
        mtime = 64'hFFFF_FFFF_FFFF_FFF6; irq[7] = 1; tick();
        mtime = 0; tick();
        chk("t6_wrap_id", {61'd0, irq_id}, 64'd7);
        chk("t6_wrap_dl", irq_dl, 64'd10);
        cfg_write(7, 1'b0, 32'h0);
        tick();
        chk("t6_dis_irq", {63'd0, irq_out}, 64'd0);
        chk("t6_dis_ip", {56'd0, ip_out}, 64'd0);
        irq[7] = 0;
        cfg_read(7, 1'b0, rd);
        chk("t6_ctrl_rd", {32'd0, rd}, 64'd0);
        tick();

        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
